// File: rtl/legendre_pkg.sv
// Shared defaults and types for the Legendre theta x r vote accumulator.
package legendre_pkg;

  localparam int unsigned DEF_DIN_W   = 31;
  localparam int unsigned DEF_THETA_W = 7;
  localparam int unsigned DEF_RIDX_W  = 6;
  localparam int unsigned DEF_R_SHIFT = 14;
  localparam int unsigned DEF_CNT_W   = 5;

  localparam int unsigned NUM_THETA = 2 ** DEF_THETA_W;
  localparam int unsigned R_BINS    = 2 ** DEF_RIDX_W;
  localparam int unsigned ADDR_W    = DEF_THETA_W + DEF_RIDX_W;

  typedef logic [ADDR_W-1:0]    vote_addr_t;
  typedef logic [DEF_CNT_W-1:0] vote_cnt_t;

  typedef struct packed {
    logic                   found;
    logic [DEF_THETA_W-1:0] theta;
    logic [DEF_RIDX_W-1:0]  rbin;
    vote_cnt_t              count;
  } peak_t;

  typedef enum logic [2:0] {
    StInit,
    StAccum,
    StDrain,
    StScan,
    StOut
  } state_e;

endpackage

// File: rtl/legendre_vote_ram.sv
// Simple dual-port vote RAM: one write, one read, two registered read stages.
module legendre_vote_ram #(
  parameter int unsigned AddrW = 13,
  parameter int unsigned DataW = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rd_q;
  logic [DataW-1:0] rdata_q;

  // Read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rd_q    <= mem_q[raddr_i];
    rdata_q <= rd_q;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/legendre_vote_accumulator.sv
// Bins signed r products into a theta x r vote RAM, then scans/clears it for the peak bin.
module legendre_vote_accumulator
  import legendre_pkg::*;
#(
  parameter int unsigned DIN_W   = DEF_DIN_W,
  parameter int unsigned THETA_W = DEF_THETA_W,
  parameter int unsigned RIDX_W  = DEF_RIDX_W,
  parameter int unsigned R_SHIFT = DEF_R_SHIFT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [THETA_W-1:0] s_theta,
  input  logic [DIN_W-1:0]   s_r,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_found,
  output logic [THETA_W-1:0] m_theta,
  output logic [RIDX_W-1:0]  m_rbin,
  output logic [CNT_W-1:0]   m_count,
  output logic [7:0]         m_dropped
);

  localparam int unsigned AddrW   = THETA_W + RIDX_W;
  localparam int unsigned NumBins = (2 ** THETA_W) * (2 ** RIDX_W);

  localparam logic [AddrW:0]          CtrBins  = NumBins[AddrW:0];
  localparam logic [AddrW:0]          CtrLast  = CtrBins - 1'b1;
  localparam logic [AddrW:0]          CtrDone  = CtrBins + 1'b1;
  localparam logic [CNT_W-1:0]        CntMax   = '1;
  localparam logic signed [DIN_W:0]   RHalf    = (DIN_W + 1)'(2 ** (RIDX_W - 1));

  typedef struct packed {
    logic               found;
    logic [THETA_W-1:0] theta;
    logic [RIDX_W-1:0]  rbin;
    logic [CNT_W-1:0]   count;
  } best_t;

  state_e state_q, state_d;
  logic [AddrW:0] ctr_q, ctr_d;

  // Binning
  logic signed [DIN_W:0] r_ext, r_shr, rb;
  logic                  in_range;
  logic [AddrW-1:0]      vote_addr;
  logic                  accept;

  assign r_ext     = {s_r[DIN_W-1], s_r};
  assign r_shr     = r_ext >>> R_SHIFT;
  assign rb        = r_shr + RHalf;
  assign in_range  = (rb[DIN_W:RIDX_W] == '0);
  assign vote_addr = {s_theta, rb[RIDX_W-1:0]};
  assign accept    = s_valid & s_ready;

  // RMW pipeline and write history for forwarding
  logic             p1_vld_q, p2_vld_q;
  logic [AddrW-1:0] p1_addr_q, p2_addr_q;
  logic             w1_vld_q, w2_vld_q;
  logic [AddrW-1:0] w1_addr_q, w2_addr_q;
  logic [CNT_W-1:0] w1_cnt_q, w2_cnt_q;
  logic [CNT_W-1:0] rmw_base, rmw_inc;

  // RAM interface
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;

  // Scan tracking
  logic             sv1_q, sv2_q;
  logic [AddrW-1:0] sa1_q, sa2_q;
  logic             scan_rd;
  best_t            best_q;
  logic [7:0]       drop_q;

  legendre_vote_ram #(
    .AddrW (AddrW),
    .DataW (CNT_W)
  ) u_ram (
    .clk_i   (ap_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Writes from the two previous cycles are not yet visible in the RAM read data.
  always_comb begin
    rmw_base = ram_rdata;
    if (w1_vld_q && (w1_addr_q == p2_addr_q)) begin
      rmw_base = w1_cnt_q;
    end else if (w2_vld_q && (w2_addr_q == p2_addr_q)) begin
      rmw_base = w2_cnt_q;
    end
    rmw_inc = (rmw_base == CntMax) ? rmw_base : rmw_base + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    scan_rd   = 1'b0;
    ram_we    = p2_vld_q;
    ram_waddr = p2_addr_q;
    ram_wdata = rmw_inc;
    ram_raddr = vote_addr;
    unique case (state_q)
      StInit: begin
        ram_we    = 1'b1;
        ram_waddr = ctr_q[AddrW-1:0];
        ram_wdata = '0;
        if (ctr_q == CtrLast) begin
          state_d = StAccum;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StAccum: begin
        s_ready = 1'b1;
        if (accept && s_last) begin
          state_d = StDrain;
          ctr_d   = '0;
        end
      end
      StDrain: begin
        if (ctr_q == 1) begin
          state_d = StScan;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StScan: begin
        if (ctr_q < CtrBins) begin
          scan_rd   = 1'b1;
          ram_raddr = ctr_q[AddrW-1:0];
          ram_we    = 1'b1;
          ram_waddr = ctr_q[AddrW-1:0];
          ram_wdata = '0;
        end
        // Last read data lands two cycles after the final address is issued.
        if (ctr_q == CtrDone) begin
          state_d = StOut;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      StOut: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = StAccum;
        end
      end
      default: begin
        state_d = StInit;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= StInit;
      ctr_q     <= '0;
      p1_vld_q  <= 1'b0;
      p1_addr_q <= '0;
      p2_vld_q  <= 1'b0;
      p2_addr_q <= '0;
      w1_vld_q  <= 1'b0;
      w1_addr_q <= '0;
      w1_cnt_q  <= '0;
      w2_vld_q  <= 1'b0;
      w2_addr_q <= '0;
      w2_cnt_q  <= '0;
      sv1_q     <= 1'b0;
      sa1_q     <= '0;
      sv2_q     <= 1'b0;
      sa2_q     <= '0;
      best_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      p1_vld_q  <= accept & in_range;
      p1_addr_q <= vote_addr;
      p2_vld_q  <= p1_vld_q;
      p2_addr_q <= p1_addr_q;
      w1_vld_q  <= p2_vld_q;
      w1_addr_q <= p2_addr_q;
      w1_cnt_q  <= rmw_inc;
      w2_vld_q  <= w1_vld_q;
      w2_addr_q <= w1_addr_q;
      w2_cnt_q  <= w1_cnt_q;
      sv1_q     <= scan_rd;
      sa1_q     <= ctr_q[AddrW-1:0];
      sv2_q     <= sv1_q;
      sa2_q     <= sa1_q;

      // Strict compare keeps the earliest scan address on ties.
      if (state_q == StDrain) begin
        best_q <= '0;
      end else if (sv2_q && (ram_rdata > best_q.count)) begin
        best_q.found <= 1'b1;
        best_q.theta <= sa2_q[AddrW-1:RIDX_W];
        best_q.rbin  <= sa2_q[RIDX_W-1:0];
        best_q.count <= ram_rdata;
      end

      if ((state_q == StOut) && m_ready) begin
        drop_q <= '0;
      end else if (accept && !in_range && (drop_q != 8'hff)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign m_found   = best_q.found;
  assign m_theta   = best_q.theta;
  assign m_rbin    = best_q.rbin;
  assign m_count   = best_q.count;
  assign m_dropped = drop_q;

endmodule
